// File: rtl/buffer_drain_pkg.sv
// buffer_drain_pkg: shared widths and FSM state type for the buffer read-side controller
package buffer_drain_pkg;
  localparam int DATA_WIDTH = 12;
  localparam int CNT_WIDTH = 16;
  typedef enum logic [1:0] {IDLE, REQ, CAP} drain_state_t;
endpackage

// File: rtl/buffer_drain_skid_queue.sv
// skid_queue: 2-entry in-order queue; head is always entry 0, a pop shifts entry 1 forward
module skid_queue
  import buffer_drain_pkg::*;
#(
  parameter int W = DATA_WIDTH
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   occupancy_o
);
  logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0] occ_q, occ_d, base;
  logic do_pop, do_push;
  always_ff @(posedge clk) begin
    if (!nrst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      occ_q <= '0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      occ_q <= occ_d;
    end
  end
  // base is the occupancy after the pop; a push lands in the first free slot behind it
  always_comb begin
    do_pop  = pop_i && (occ_q != 2'd0);
    base    = occ_q - {1'b0, do_pop};
    do_push = push_i && (base != 2'd2);
    occ_d   = base + {1'b0, do_push};
    e0_d    = (do_push && base == 2'd0) ? data_i : (do_pop ? e1_q : e0_q);
    e1_d    = (do_push && base == 2'd1) ? data_i : e1_q;
  end
  assign head_o      = e0_q;
  assign occupancy_o = occ_q;
endmodule

// File: rtl/buffer_drain.sv
// buffer_drain: pops the sample buffer one word per REQ/CAP pair and streams words out through a
// 2-entry queue, never reading an empty buffer and never dropping a word under back-pressure
module buffer_drain
  import buffer_drain_pkg::*;
#(
  parameter int DATA_WIDTH = buffer_drain_pkg::DATA_WIDTH,
  parameter int CNT_WIDTH  = buffer_drain_pkg::CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  enable,
  input  logic                  buf_empty,
  input  logic [DATA_WIDTH-1:0] buf_data,
  output logic                  buf_read,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic                  busy
);
  drain_state_t state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0] occ;
  logic [2:0] post_occ;
  logic capture, hs;
  skid_queue #(.W(DATA_WIDTH)) u_queue (
    .clk         (clk),
    .nrst        (nrst),
    .push_i      (capture),
    .pop_i       (m_ready),
    .data_i      (buf_data),
    .head_o      (m_data),
    .occupancy_o (occ)
  );
  assign capture  = (state_q == CAP);
  assign hs       = m_valid && m_ready;
  assign post_occ = {1'b0, occ} + 3'd1 - {2'b0, hs};
  assign cnt_d    = cnt_q + CNT_WIDTH'(hs);
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // buf_empty is deliberately ignored in REQ: it only reflects the pop on the following cycle
  always_comb begin
    state_d = IDLE;
    unique case (state_q)
      IDLE:    state_d = (enable && !buf_empty && occ < 2'd2) ? REQ : IDLE;
      REQ:     state_d = CAP;
      CAP:     state_d = (enable && !buf_empty && post_occ < 3'd2) ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    buf_read   = (state_q == REQ);
    m_valid    = (occ != 2'd0);
    busy       = (state_q != IDLE) || (occ != 2'd0);
    word_count = cnt_q;
  end
endmodule
